// File: rtl/output_accum_quant.sv
// output_accum_quant: accumulates PASSES signed beats per lane into one pixel,
// quantises each lane with ReLU, arithmetic right shift and unsigned
// saturation, and queues the {qa,qb} pair in a first-word-fall-through FIFO.
module output_accum_quant #(
    parameter int IN_W       = 16,
    parameter int ACC_W      = 20,
    parameter int OUT_W      = 8,
    parameter int PASSES     = 4,
    parameter int SHIFT      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           in_valid,
    input  logic [IN_W-1:0]                ina,
    input  logic [IN_W-1:0]                inb,
    output logic                           in_ready,
    input  logic                           out_rd,
    output logic [2*OUT_W-1:0]             out_data,
    output logic                           out_valid,
    output logic                           fifo_full,
    output logic                           drop_flag,
    output logic [$clog2(PASSES+1)-1:0]    pass_cnt,
    output logic [1:0]                     state_o
);

    localparam int CNT_W  = $clog2(PASSES + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int EXT_W  = ACC_W - IN_W;

    localparam logic [CNT_W-1:0]  PASS_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  PASS_LAST = CNT_W'(PASSES - 1);
    localparam logic [FCNT_W-1:0] FIFO_MAX  = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_QUANT = 2'd2,
        ST_PUSH  = 2'd3
    } state_t;

    state_t                     state_r;
    logic signed [ACC_W-1:0]    acc_a_r;
    logic signed [ACC_W-1:0]    acc_b_r;
    logic [CNT_W-1:0]           pass_cnt_r;
    logic [OUT_W-1:0]           qa_r;
    logic [OUT_W-1:0]           qb_r;
    logic                       drop_r;

    logic [2*OUT_W-1:0]         mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_r;
    logic [PTR_W-1:0]           rd_ptr_r;
    logic [FCNT_W-1:0]          count_r;

    logic                       accept_s;
    logic                       push_s;
    logic                       pop_s;
    logic                       full_s;
    logic                       empty_s;
    logic signed [ACC_W-1:0]    sext_a_s;
    logic signed [ACC_W-1:0]    sext_b_s;

    // ReLU, arithmetic shift, then clamp to the unsigned output range.
    function automatic logic [OUT_W-1:0] quant_lane(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] r;
        r = acc >>> SHIFT;
        if (acc[ACC_W-1]) begin
            quant_lane = {OUT_W{1'b0}};
        end else if (|r[ACC_W-1:OUT_W]) begin
            quant_lane = {OUT_W{1'b1}};
        end else begin
            quant_lane = r[OUT_W-1:0];
        end
    endfunction

    assign sext_a_s = {{EXT_W{ina[IN_W-1]}}, ina};
    assign sext_b_s = {{EXT_W{inb[IN_W-1]}}, inb};

    assign full_s   = (count_r == FIFO_MAX);
    assign empty_s  = (count_r == {FCNT_W{1'b0}});
    assign in_ready = (state_r == ST_IDLE) || (state_r == ST_ACCUM);
    assign accept_s = in_valid & in_ready & en;
    // A full FIFO still takes the write when the head is popped the same cycle.
    assign push_s   = (state_r == ST_PUSH) & en & (~full_s | out_rd);
    // A pop of an empty FIFO is ignored even if a write lands that cycle.
    assign pop_s    = out_rd & ~empty_s;

    assign out_valid = ~empty_s;
    assign fifo_full = full_s;
    assign out_data  = empty_s ? {(2*OUT_W){1'b0}} : mem_r[rd_ptr_r];
    assign drop_flag = drop_r;
    assign pass_cnt  = pass_cnt_r;
    assign state_o   = state_r;

    // Accumulate/quantise FSM; everything holds while en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            acc_a_r    <= {ACC_W{1'b0}};
            acc_b_r    <= {ACC_W{1'b0}};
            pass_cnt_r <= {CNT_W{1'b0}};
            qa_r       <= {OUT_W{1'b0}};
            qb_r       <= {OUT_W{1'b0}};
        end else if (en) begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        acc_a_r    <= sext_a_s;
                        acc_b_r    <= sext_b_s;
                        pass_cnt_r <= PASS_ONE;
                        state_r    <= (PASSES == 1) ? ST_QUANT : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept_s) begin
                        acc_a_r    <= acc_a_r + sext_a_s;
                        acc_b_r    <= acc_b_r + sext_b_s;
                        pass_cnt_r <= pass_cnt_r + PASS_ONE;
                        if (pass_cnt_r == PASS_LAST) begin
                            state_r <= ST_QUANT;
                        end
                    end
                end
                ST_QUANT: begin
                    qa_r    <= quant_lane(acc_a_r);
                    qb_r    <= quant_lane(acc_b_r);
                    state_r <= ST_PUSH;
                end
                ST_PUSH: begin
                    if (push_s) begin
                        pass_cnt_r <= {CNT_W{1'b0}};
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output FIFO storage, pointers and occupancy; independent of en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {(2*OUT_W){1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {FCNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {qa_r, qb_r};
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + FCNT_W'(1);
                2'b01:   count_r <= count_r - FCNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky flag for beats offered while the FSM could not take them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_r <= 1'b0;
        end else if (in_valid & en & ~in_ready) begin
            drop_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_output_accum_quant.sv
// tb_output_accum_quant: directed, table-driven checks of output_accum_quant.
module tb_output_accum_quant;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic [15:0] ina;
    logic [15:0] inb;
    logic        in_ready;
    logic        out_rd;
    logic [15:0] out_data;
    logic        out_valid;
    logic        fifo_full;
    logic        drop_flag;
    logic [2:0]  pass_cnt;
    logic [1:0]  state_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  qa;
        logic [7:0]  qb;
    } vec_t;

    vec_t vecs [7];

    output_accum_quant dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .ina       (ina),
        .inb       (inb),
        .in_ready  (in_ready),
        .out_rd    (out_rd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .fifo_full (fifo_full),
        .drop_flag (drop_flag),
        .pass_cnt  (pass_cnt),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beats(input logic [15:0] a, input logic [15:0] b, input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            ina      = a;
            inb      = b;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic pop();
        out_rd = 1'b1;
        tick();
        out_rd = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'd100,   16'hFFCE, 8'd25,  8'd0};
        vecs[1] = '{16'h7FFF,  16'h0010, 8'd255, 8'd4};
        vecs[2] = '{16'hFFFF,  16'd16,   8'd0,   8'd4};
        vecs[3] = '{16'd64,    16'd63,   8'd16,  8'd15};
        vecs[4] = '{16'h8000,  16'd1023, 8'd0,   8'd255};
        vecs[5] = '{16'd1024,  16'd4,    8'd255, 8'd1};
        vecs[6] = '{16'd15,    16'd16,   8'd3,   8'd4};

        rst = 1'b0; en = 1'b1; in_valid = 1'b0; ina = 16'd0; inb = 16'd0; out_rd = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 16'd0);
        chk("rst_state", state_o, 2'd0);
        chk("rst_pass_cnt", pass_cnt, 3'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_fifo_full", fifo_full, 1'b0);
        chk("rst_drop", drop_flag, 1'b0);
        rst = 1'b1;
        tick();

        // Table: one pixel per vector, observe latency and the quantised pair.
        for (int i = 0; i < 7; i++) begin
            send_beats(vecs[i].a, vecs[i].b, 4);
            chk("vec_quant_state", state_o, 2'd2);
            chk("vec_pass_cnt_full", pass_cnt, 3'd4);
            chk("vec_in_ready_low", in_ready, 1'b0);
            tick();
            chk("vec_push_state", state_o, 2'd3);
            chk("vec_not_yet_valid", out_valid, 1'b0);
            tick();
            chk("vec_out_valid", out_valid, 1'b1);
            chk("vec_out_data", out_data, {vecs[i].qa, vecs[i].qb});
            chk("vec_idle_state", state_o, 2'd0);
            chk("vec_pass_cnt_clr", pass_cnt, 3'd0);
            pop();
            chk("vec_drained", out_valid, 1'b0);
        end

        // Fill the FIFO, stall the ninth pixel, drop a beat, release with a pop.
        for (int i = 1; i <= 8; i++) begin
            send_beats(16'(16 * i), 16'(32 * i), 4);
            tick();
            tick();
        end
        chk("fill_full", fifo_full, 1'b1);
        chk("fill_head", out_data, {8'd4, 8'd8});
        send_beats(16'd144, 16'd288, 4);
        tick();
        tick();
        chk("stall_state", state_o, 2'd3);
        tick();
        chk("stall_state_hold", state_o, 2'd3);
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_no_drop_yet", drop_flag, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("drop_set", drop_flag, 1'b1);
        tick();
        tick();
        chk("drop_sticky", drop_flag, 1'b1);
        chk("stall_state_still", state_o, 2'd3);
        pop();
        chk("release_idle", state_o, 2'd0);
        chk("release_full_kept", fifo_full, 1'b1);
        chk("release_new_head", out_data, {8'd8, 8'd16});
        for (int i = 2; i <= 9; i++) begin
            chk("drain_order", out_data, {8'(4 * i), 8'(8 * i)});
            pop();
        end
        chk("drain_empty", out_valid, 1'b0);
        chk("drain_drop_sticky", drop_flag, 1'b1);

        // en low for 5 cycles in the middle of a pixel.
        send_beats(16'd100, 16'd200, 2);
        chk("en_pre_cnt", pass_cnt, 3'd2);
        en       = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("en_hold_cnt", pass_cnt, 3'd2);
            chk("en_hold_state", state_o, 2'd1);
        end
        in_valid = 1'b0;
        en       = 1'b1;
        send_beats(16'd100, 16'd200, 2);
        tick();
        tick();
        chk("en_resume_data", out_data, {8'd25, 8'd50});
        pop();
        chk("en_resume_drained", out_valid, 1'b0);

        // Asynchronous reset mid-pixel with three FIFO entries.
        for (int i = 0; i < 3; i++) begin
            send_beats(16'd16, 16'd16, 4);
            tick();
            tick();
        end
        send_beats(16'd5, 16'd5, 2);
        chk("pre_rst_state", state_o, 2'd1);
        chk("pre_rst_valid", out_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_out_data", out_data, 16'd0);
        chk("arst_fifo_full", fifo_full, 1'b0);
        chk("arst_drop", drop_flag, 1'b0);
        chk("arst_pass_cnt", pass_cnt, 3'd0);
        chk("arst_state", state_o, 2'd0);
        chk("arst_in_ready", in_ready, 1'b1);
        #3;
        rst = 1'b1;
        tick();
        send_beats(16'd32, 16'd48, 4);
        tick();
        tick();
        chk("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_data", out_data, {8'd8, 8'd12});
        pop();
        chk("post_rst_one_entry", out_valid, 1'b0);

        // Back-to-back pixels with out_rd held high.
        out_rd = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            send_beats(16'(64 * j), 16'(8 * j), 4);
            tick();
            tick();
            chk("b2b_valid", out_valid, 1'b1);
            chk("b2b_data", out_data, {8'(16 * j), 8'(2 * j)});
        end
        tick();
        out_rd = 1'b0;
        chk("b2b_empty", out_valid, 1'b0);
        chk("b2b_no_drop", drop_flag, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
